// File: rtl/tx_frame_buffer_pkg.sv
// Shared types and constants for the TX frame buffer.
// Optional statistics counters are built when TX_BUF_STATS_EN is defined.
package tx_frame_buffer_pkg;

    // Width of the BUSY-rise timeout counter (covers TMO_CYCLES up to 255).
    localparam int unsigned TMO_CNT_W   = 8;
    // Width of the drop/timeout statistics counters.
    localparam int unsigned STATS_CNT_W = 8;

    // Transmit pacing FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_HI = 2'b01,
        WAIT_LO = 2'b10
    } tx_state_e;

    // Saturating increment for statistics counters.
    function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
        return (v == '1) ? v : v + STATS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tx_buf_mem.sv
// Depth x Width byte storage: one synchronous write port, combinational read.
// Storage has no reset; validity is tracked by the pointers in the parent.
module tx_buf_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data_c
);

    logic [Width-1:0] mem [Depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/tx_frame_buffer.sv
// TX byte FIFO with busy-handshake pacing toward the UART data synchronizer.
// Releases one byte per TX_D_VLD pulse, then waits for BUSY to rise and fall.
// Define TX_BUF_STATS_EN to add saturating DROP_CNT / TMO_CNT outputs.
module tx_frame_buffer
    import tx_frame_buffer_pkg::*;
#(
    parameter int unsigned Width      = 8,
    parameter int unsigned Depth      = 8,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [Width-1:0]         WR_DATA,
    input  logic                     WR_VLD,
    input  logic                     BUSY,
    output logic [Width-1:0]         TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(Depth):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     TIMEOUT
`ifdef TX_BUF_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0]   DROP_CNT,
    output logic [STATS_CNT_W-1:0]   TMO_CNT
`endif
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_nxt;
    logic [Width-1:0]     rd_data_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 drop_c;
    tx_state_e            state;
    logic [TMO_CNT_W-1:0] tmo_cnt;

    tx_buf_mem #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (AW)
    ) u_mem (
        .clk       (CLK),
        .wr_en     (push_c),
        .wr_addr   (wr_ptr),
        .wr_data   (WR_DATA),
        .rd_addr   (rd_ptr),
        .rd_data_c (rd_data_c)
    );

    // Push/pop qualification and next occupancy.
    always_comb begin
        push_c    = WR_VLD && !FULL;
        drop_c    = WR_VLD && FULL;
        pop_c     = (state == IDLE) && !EMPTY && !BUSY;
        count_nxt = COUNT;
        if (push_c && !pop_c) begin
            count_nxt = COUNT + CW'(1);
        end else if (!push_c && pop_c) begin
            count_nxt = COUNT - CW'(1);
        end
    end

    // Pointers, occupancy flags and overflow pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            COUNT    <= count_nxt;
            FULL     <= (count_nxt == CW'(Depth));
            EMPTY    <= (count_nxt == '0);
            OVERFLOW <= drop_c;
        end
    end

    // Pacing FSM: pop from IDLE, then wait for BUSY rise (with timeout) and fall.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            TX_D_VLD <= 1'b0;
            TIMEOUT  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        TX_P_DATA <= rd_data_c;
                        TX_D_VLD  <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (BUSY) begin
                        state <= WAIT_LO;
                    end else if (tmo_cnt == TMO_CNT_W'(TMO_CYCLES - 1)) begin
                        // UART never accepted the byte; drop it and move on.
                        TIMEOUT <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!BUSY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_BUF_STATS_EN
    // Saturating drop and timeout event counters, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DROP_CNT <= '0;
            TMO_CNT  <= '0;
        end else begin
            if (drop_c) begin
                DROP_CNT <= sat_inc(DROP_CNT);
            end
            if ((state == WAIT_HI) && !BUSY && (tmo_cnt == TMO_CNT_W'(TMO_CYCLES - 1))) begin
                TMO_CNT <= sat_inc(TMO_CNT);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed self-checking bench for tx_frame_buffer (Width=8, Depth=8, TMO_CYCLES=255).
module tb_tx_frame_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_vld;
    logic       busy;
    logic [7:0] tx_p_data;
    logic       tx_d_vld;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       timeout;
`ifdef TX_BUF_STATS_EN
    logic [7:0] drop_cnt;
    logic [7:0] tmo_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    tx_frame_buffer #(
        .Width      (8),
        .Depth      (8),
        .TMO_CYCLES (255)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .WR_DATA   (wr_data),
        .WR_VLD    (wr_vld),
        .BUSY      (busy),
        .TX_P_DATA (tx_p_data),
        .TX_D_VLD  (tx_d_vld),
        .FULL      (full),
        .EMPTY     (empty),
        .COUNT     (count),
        .OVERFLOW  (overflow),
        .TIMEOUT   (timeout)
`ifdef TX_BUF_STATS_EN
        ,
        .DROP_CNT  (drop_cnt),
        .TMO_CNT   (tmo_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // BUSY idles 3 cycles after a pulse, rises for 20 cycles, then falls.
    task automatic busy_cycle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_pulse_pre_busy", 32'(tx_d_vld), 32'd0);
        end
        busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_pulse_busy_hi", 32'(tx_d_vld), 32'd0);
        end
        busy = 1'b0;
        tick();
        chk("no_pulse_at_busy_fall", 32'(tx_d_vld), 32'd0);
    endtask

    // Fastest handshake from WAIT_HI: next byte pops 3 cycles after previous pulse.
    task automatic handshake_next(input logic [7:0] exp);
        busy = 1'b1;
        tick();
        chk("hs_no_pulse_hi", 32'(tx_d_vld), 32'd0);
        busy = 1'b0;
        tick();
        chk("hs_no_pulse_lo", 32'(tx_d_vld), 32'd0);
        tick();
        chk("hs_pulse", 32'(tx_d_vld), 32'd1);
        chk("hs_data", 32'(tx_p_data), 32'(exp));
    endtask

    task automatic finish_hs();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = 8'(base + 8'(i));
            wr_vld  = 1'b1;
            tick();
        end
        wr_vld = 1'b0;
    endtask

    task automatic drain(input logic [7:0] base, input int n);
        busy = 1'b0;
        tick();
        chk("drain_first_pulse", 32'(tx_d_vld), 32'd1);
        chk("drain_first_data", 32'(tx_p_data), 32'(base));
        for (int i = 1; i < n; i++) begin
            handshake_next(8'(base + 8'(i)));
        end
        finish_hs();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        int  k;
        logic saw_vld;

        rst_n   = 1'b0;
        wr_data = 8'h00;
        wr_vld  = 1'b0;
        busy    = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_vld", 32'(tx_d_vld), 32'd0);
        chk("rst_data", 32'(tx_p_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single byte, one-cycle latency through the buffer
        wr_data = 8'hA5;
        wr_vld  = 1'b1;
        tick();
        wr_vld = 1'b0;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_empty0", 32'(empty), 32'd0);
        chk("t1_no_bypass", 32'(tx_d_vld), 32'd0);
        tick();
        chk("t1_pulse", 32'(tx_d_vld), 32'd1);
        chk("t1_data", 32'(tx_p_data), 32'hA5);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty1", 32'(empty), 32'd1);
        finish_hs();
        chk("t1_single_pulse", 32'(tx_d_vld), 32'd0);

        // 2: two back-to-back bytes paced by a slow BUSY handshake
        wr_data = 8'h12;
        wr_vld  = 1'b1;
        tick();
        chk("t2_count_after_first", 32'(count), 32'd1);
        wr_data = 8'h34;
        tick();
        wr_vld = 1'b0;
        chk("t2_pulse1", 32'(tx_d_vld), 32'd1);
        chk("t2_data1", 32'(tx_p_data), 32'h12);
        chk("t2_count_pushpop", 32'(count), 32'd1);
        busy_cycle();
        tick();
        chk("t2_pulse2", 32'(tx_d_vld), 32'd1);
        chk("t2_data2", 32'(tx_p_data), 32'h34);
        busy_cycle();
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_data_held", 32'(tx_p_data), 32'h34);

        // 3: fill while BUSY blocks, then overflow on the 9th write
        fill(8'h80, 8);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count8", 32'(count), 32'd8);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        wr_data = 8'h88;
        wr_vld  = 1'b1;
        tick();
        wr_vld = 1'b0;
        chk("t3_ovf_pulse", 32'(overflow), 32'd1);
        chk("t3_count_still8", 32'(count), 32'd8);
        chk("t3_still_full", 32'(full), 32'd1);
        tick();
        chk("t3_ovf_one_cycle", 32'(overflow), 32'd0);
        chk("t3_busy_blocks_pop", 32'(tx_d_vld), 32'd0);
`ifdef TX_BUF_STATS_EN
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // 4: BUSY never rises after a pop -> TIMEOUT after 255 cycles
        busy = 1'b0;
        tick();
        chk("t4_pulse", 32'(tx_d_vld), 32'd1);
        chk("t4_data", 32'(tx_p_data), 32'h80);
        chk("t4_count7", 32'(count), 32'd7);
        k       = 0;
        saw_vld = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (tx_d_vld) saw_vld = 1'b1;
            if (timeout) begin
                k = i;
                break;
            end
        end
        chk("t4_tmo_latency", 32'(k), 32'd255);
        chk("t4_no_pulse_while_waiting", 32'(saw_vld), 32'd0);
        tick();
        chk("t4_tmo_one_cycle", 32'(timeout), 32'd0);
        chk("t4_next_pulse", 32'(tx_d_vld), 32'd1);
        chk("t4_next_data", 32'(tx_p_data), 32'h81);
`ifdef TX_BUF_STATS_EN
        chk("t4_tmo_cnt", 32'(tmo_cnt), 32'd1);
`endif
        for (int i = 2; i < 8; i++) begin
            handshake_next(8'(8'h80 + 8'(i)));
        end
        finish_hs();
        chk("t4_empty", 32'(empty), 32'd1);

        // 5: two full fill/drain rounds across the pointer wrap
        fill(8'h00, 8);
        chk("t5_full_a", 32'(full), 32'd1);
        drain(8'h00, 8);
        fill(8'h08, 8);
        chk("t5_full_b", 32'(full), 32'd1);
        drain(8'h08, 8);

        // 6: asynchronous reset while in WAIT_LO with 5 bytes queued
        fill(8'h40, 6);
        busy = 1'b0;
        tick();
        chk("t6_pulse", 32'(tx_d_vld), 32'd1);
        chk("t6_count5", 32'(count), 32'd5);
        busy = 1'b1;
        tick();
        chk("t6_count5_wait_lo", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_vld", 32'(tx_d_vld), 32'd0);
        chk("t6_rst_data", 32'(tx_p_data), 32'd0);
        busy = 1'b0;
        tick();
        rst_n   = 1'b1;
        saw_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_d_vld) saw_vld = 1'b1;
        end
        chk("t6_no_pulse_after_rst", 32'(saw_vld), 32'd0);
        chk("t6_empty_after_rst", 32'(empty), 32'd1);
        wr_data = 8'h5A;
        wr_vld  = 1'b1;
        tick();
        wr_vld = 1'b0;
        chk("t6_new_no_bypass", 32'(tx_d_vld), 32'd0);
        tick();
        chk("t6_new_pulse", 32'(tx_d_vld), 32'd1);
        chk("t6_new_data", 32'(tx_p_data), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_buffer.md
Name: tx_frame_buffer

Overview:
- Byte FIFO plus transmit pacing FSM in the REF_CLK domain, placed between the system controller's TX byte output and the TX data synchronizer feeding the UART transmitter.
- Absorbs multi-byte responses (e.g. 16-bit ALU result = 2 bytes) issued back-to-back by the controller.
- Releases one byte at a time as a single-cycle valid pulse, only when the synchronized UART busy is low.
- Waits for the busy rise/fall handshake before releasing the next byte.

Parameters:
- Width, 8, data byte width.
- Depth, 8, FIFO entries; power of 2, minimum 2.
- TMO_CYCLES, 255, max CLK cycles to wait for BUSY to rise after a pop; 1..255.

Ports:
- CLK  input  1  REF_CLK domain clock.
- RST  input  1  reset; asynchronous assert, active-low (synchronized upstream).
- WR_DATA  input  Width  byte from system controller.
- WR_VLD  input  1  write strobe; one byte per cycle high.
- BUSY  input  1  UART TX busy, already bit-synchronized to CLK.
- TX_P_DATA  output  Width  byte to TX data synchronizer; held stable between pops.
- TX_D_VLD  output  1  one-cycle pulse per released byte.
- FULL  output  1  count == Depth.
- EMPTY  output  1  count == 0.
- COUNT  output  $clog2(Depth)+1  occupancy.
- OVERFLOW  output  1  one-cycle pulse: write dropped.
- TIMEOUT  output  1  one-cycle pulse: BUSY never rose after a pop.

Behaviour:
- Reset, asynchronous on RST low:
  - pointers and count 0, FSM IDLE, timeout counter 0.
  - TX_P_DATA 0, TX_D_VLD 0, OVERFLOW 0, TIMEOUT 0, FULL 0, EMPTY 1.
  - Reset mid-transfer discards all stored bytes; no pulse is issued after release.
- All outputs registered. FULL/EMPTY/COUNT reflect state after the last edge.
- Push:
  - Accepted at an edge with WR_VLD=1 and FULL=0: mem[wr_ptr] <= WR_DATA, wr_ptr++, mod Depth with natural wrap.
  - WR_VLD=1 with FULL=1: byte dropped, OVERFLOW=1 next cycle. This holds even if a pop occurs the same edge.
- Pop: only from IDLE with EMPTY=0 and BUSY=0. At that edge:
  - TX_P_DATA <= mem[rd_ptr], rd_ptr++, TX_D_VLD=1 for exactly one cycle.
  - FSM -> WAIT_HI, timeout counter cleared.
- Simultaneous accepted push and pop: COUNT unchanged; both pointers advance.
- Latency: byte pushed into an empty buffer with BUSY=0 at edge N appears with TX_D_VLD=1 after edge N+1. EMPTY is never bypassed.
- FSM:
  - IDLE: pop condition -> WAIT_HI; else stay.
  - WAIT_HI: BUSY=1 -> WAIT_LO. Counter reaches TMO_CYCLES with BUSY=0 -> IDLE, TIMEOUT=1 for one cycle; byte counted as lost, no retransmit.
  - WAIT_LO: BUSY=0 -> IDLE. No timeout; the UART frame length is bounded.
- Minimum spacing between TX_D_VLD pulses is 3 CLK cycles. The handshake guarantees the Data_Sync enable pulse is never overrun.
- BUSY high while in IDLE blocks popping; there is no timeout in IDLE.

Optional Feature:
- Macro TX_BUF_STATS_EN.
- Defined:
  - Adds outputs DROP_CNT[7:0] and TMO_CNT[7:0].
  - Each is an 8-bit counter, saturating at 255.
  - DROP_CNT increments on every OVERFLOW; TMO_CNT on every TIMEOUT.
  - Both clear only on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE=2'b00, WAIT_HI=2'b01, WAIT_LO=2'b10.
  - Counter width constant for TMO_CYCLES (8 bits).
  - Stats counter width (8).
- Sub-module tx_buf_mem: Depth x Width register array with write port (wr_en, wr_addr, wr_data) and combinational read at rd_addr. No reset on storage.
- Top holds pointers, count, FSM, and pulse generation.

Test Plan:
1. Reset, then write 0xA5 with BUSY=0 -> TX_D_VLD pulse one cycle later with TX_P_DATA=0xA5; COUNT 1->0; EMPTY=1.
2. Push 0x12, 0x34 back-to-back; BUSY rises 4 cycles after each pulse and falls 20 cycles later -> exactly two pulses, 0x12 then 0x34. Second pulse occurs no earlier than 1 cycle after BUSY falls.
3. Hold BUSY=1, push 9 bytes with Depth=8 -> FULL=1 after the 8th; the 9th gives OVERFLOW pulse; COUNT=8. With TX_BUF_STATS_EN, DROP_CNT=1.
4. Pop with BUSY held 0 -> TIMEOUT pulse exactly TMO_CYCLES=255 cycles after TX_D_VLD; FSM back to IDLE. Next queued byte pops one cycle later.
5. Fill 8 bytes, drain fully, refill 8 bytes across the pointer wrap -> output order matches input order (0x00..0x0F), no loss.
6. Assert RST low while in WAIT_LO with COUNT=5 -> immediately COUNT=0, EMPTY=1, TX_D_VLD=0, TX_P_DATA=0. After release, no pulse occurs until a new write.
